// File: rtl/tone_pkg.sv
// tone_pkg: shared constants and helpers for the tone synthesiser.
//   AMP_MAX_DEFAULT : default peak amplitude at full volume
//   amp_of()        : volume code -> amplitude (AMP_MAX shifted right by the volume deficit)
//   sat()           : clamp a wide signed sum into a w-bit signed range
package tone_pkg;

    localparam int AMP_MAX_DEFAULT = 24575;

    function automatic int amp_of(input int vol, input int vol_w, input int amp_max);
        return (vol == 0) ? 0 : amp_max >> ((1 << vol_w) - 1 - vol);
    endfunction

    function automatic longint sat(input longint sum, input int w);
        longint hi;
        longint lo;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -hi - 1;
        return (sum > hi) ? hi : (sum < lo) ? lo : sum;
    endfunction

endpackage

// File: rtl/tone_channel.sv
// tone_channel: one square-wave tone voice with boundary-aligned retuning.
//   clk, rst  : system clock, asynchronous active-high reset
//   note_div  : half-period in clk cycles, 0 = off (sampled only when idle or at a boundary)
//   volume    : volume code, 0 = silent
//   mute      : forces the sample to 0 while the divider keeps running
//   sample    : registered signed sample, +A in phase 0, -A in phase 1
//   tick      : one-cycle pulse after each completed full period
module tone_channel
    import tone_pkg::*;
#(
    parameter int DIV_W    = 22,
    parameter int SAMPLE_W = 16,
    parameter int VOL_W    = 3,
    parameter int AMP_MAX  = AMP_MAX_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DIV_W-1:0]    note_div,
    input  logic [VOL_W-1:0]    volume,
    input  logic                mute,
    output logic [SAMPLE_W-1:0] sample,
    output logic                tick
);

    logic [DIV_W-1:0]    div_q;
    logic [DIV_W-1:0]    cnt;
    logic                phase;
    logic                wrap;
    logic                active;
    logic                boundary;
    int                  amp_i;
    logic [SAMPLE_W-1:0] amp;
    logic [SAMPLE_W-1:0] sample_d;

    always_comb begin
        active   = div_q != '0;
        boundary = active && (cnt == div_q - 1'b1);
        amp_i    = amp_of(int'(volume), VOL_W, AMP_MAX);
        amp      = amp_i[SAMPLE_W-1:0];
        sample_d = (active && !mute) ? (phase ? -amp : amp) : '0;
    end

    // wrap marks the 1->0 phase transition; it is delayed one more stage so
    // that tick lines up with the sample that first shows the new period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= '0;
            cnt    <= '0;
            phase  <= 1'b0;
            wrap   <= 1'b0;
            tick   <= 1'b0;
            sample <= '0;
        end else begin
            wrap   <= boundary && phase;
            tick   <= wrap;
            sample <= sample_d;
            if (!active) begin
                div_q <= note_div;
                cnt   <= '0;
                phase <= 1'b0;
            end else if (boundary) begin
                div_q <= note_div;
                cnt   <= '0;
                // going idle always leaves phase at 0 so a restart begins at +A
                phase <= (note_div != '0) && !phase;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tone_synth.sv
// tone_synth: NUM_CH square-wave tone channels summed by a saturating mixer.
//   clk, rst    : system clock, asynchronous active-high reset
//   note_div    : per-channel half-period, channel i at [i*DIV_W +: DIV_W]
//   volume      : per-channel volume code, channel i at [i*VOL_W +: VOL_W]
//   mute        : per-channel mute
//   ch_sample   : registered per-channel signed samples
//   mix_sample  : registered saturated sum of ch_sample
//   period_tick : per-channel full-period pulse
module tone_synth
    import tone_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int DIV_W    = 22,
    parameter int SAMPLE_W = 16,
    parameter int VOL_W    = 3,
    parameter int AMP_MAX  = AMP_MAX_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH*DIV_W-1:0]    note_div,
    input  logic [NUM_CH*VOL_W-1:0]    volume,
    input  logic [NUM_CH-1:0]          mute,
    output logic [NUM_CH*SAMPLE_W-1:0] ch_sample,
    output logic [SAMPLE_W-1:0]        mix_sample,
    output logic [NUM_CH-1:0]          period_tick
);

    // one guard bit beyond the channel-count growth keeps the sum exact
    localparam int SUM_W = SAMPLE_W + $clog2(NUM_CH) + 1;

    logic signed [SUM_W-1:0] sum;
    logic signed [63:0]      clamped;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tone_channel #(
            .DIV_W   (DIV_W),
            .SAMPLE_W(SAMPLE_W),
            .VOL_W   (VOL_W),
            .AMP_MAX (AMP_MAX)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .note_div(note_div[i*DIV_W +: DIV_W]),
            .volume  (volume[i*VOL_W +: VOL_W]),
            .mute    (mute[i]),
            .sample  (ch_sample[i*SAMPLE_W +: SAMPLE_W]),
            .tick    (period_tick[i])
        );
    end

    always_comb begin
        sum = '0;
        for (int c = 0; c < NUM_CH; c++)
            sum = sum + SUM_W'($signed(ch_sample[c*SAMPLE_W +: SAMPLE_W]));
        clamped = sat(64'(sum), SAMPLE_W);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mix_sample <= '0;
        else
            mix_sample <= clamped[SAMPLE_W-1:0];
    end

endmodule

// File: tb/tb_tone_synth.sv
// tb_tone_synth: self-checking bench with an event-time reference model.
module tb_tone_synth;

    localparam int NUM_CH   = 2;
    localparam int DIV_W    = 22;
    localparam int SAMPLE_W = 16;
    localparam int VOL_W    = 3;
    localparam int AMP_MAX  = 24575;
    localparam int FULL     = 24575;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NUM_CH*DIV_W-1:0]    note_div;
    logic [NUM_CH*VOL_W-1:0]    volume;
    logic [NUM_CH-1:0]          mute;
    logic [NUM_CH*SAMPLE_W-1:0] ch_sample;
    logic [SAMPLE_W-1:0]        mix_sample;
    logic [NUM_CH-1:0]          period_tick;

    tone_synth #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .SAMPLE_W(SAMPLE_W), .VOL_W(VOL_W), .AMP_MAX(AMP_MAX)
    ) dut (
        .clk(clk), .rst(rst), .note_div(note_div), .volume(volume), .mute(mute),
        .ch_sample(ch_sample), .mix_sample(mix_sample), .period_tick(period_tick)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: each active channel remembers the absolute edge at
    // which its current half-period ends, rather than counting cycles.
    longint cyc;
    bit     m_act [NUM_CH];
    bit     m_ph  [NUM_CH];
    bit     m_tk  [NUM_CH];
    longint m_end [NUM_CH];
    int     e_samp[NUM_CH];
    int     e_tick[NUM_CH];
    int     e_mix;

    typedef struct {
        int vol;
        int amp;
    } amp_vec_t;
    amp_vec_t amp_tab[8];

    function automatic int amp_ref(input int v);
        return (v == 0) ? 0 : AMP_MAX / (1 << ((1 << VOL_W) - 1 - v));
    endfunction

    function automatic int clamp(input longint s);
        longint hi = (longint'(1) << (SAMPLE_W - 1)) - 1;
        return int'((s > hi) ? hi : (s < -hi - 1) ? -hi - 1 : s);
    endfunction

    function automatic int dut_samp(input int c);
        return int'($signed(ch_sample[c*SAMPLE_W +: SAMPLE_W]));
    endfunction

    task automatic chk(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        cyc   = 0;
        e_mix = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_act[c] = 0; m_ph[c] = 0; m_tk[c] = 0; m_end[c] = 0;
            e_samp[c] = 0; e_tick[c] = 0;
        end
    endtask

    task automatic model_edge();
        longint s = 0;
        for (int c = 0; c < NUM_CH; c++) s += e_samp[c];
        e_mix = clamp(s);
        for (int c = 0; c < NUM_CH; c++) begin
            int a = amp_ref(int'(volume[c*VOL_W +: VOL_W]));
            int nd = int'(note_div[c*DIV_W +: DIV_W]);
            e_samp[c] = (m_act[c] && !mute[c]) ? (m_ph[c] ? -a : a) : 0;
            e_tick[c] = m_tk[c];
            m_tk[c] = 0;
            if (!m_act[c]) begin
                if (nd != 0) begin
                    m_act[c] = 1; m_ph[c] = 0; m_end[c] = cyc + nd;
                end
            end else if (cyc == m_end[c]) begin
                if (m_ph[c]) m_tk[c] = 1;
                if (nd == 0) begin
                    m_act[c] = 0; m_ph[c] = 0;
                end else begin
                    m_ph[c] = !m_ph[c]; m_end[c] = cyc + nd;
                end
            end
        end
        cyc++;
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            chk($sformatf("ch_sample[%0d]", c), dut_samp(c), e_samp[c]);
            chk($sformatf("period_tick[%0d]", c), period_tick[c], e_tick[c]);
        end
        chk("mix_sample", $signed(mix_sample), e_mix);
    endtask

    task automatic set_ch(input int c, input int nd, input int v, input bit m);
        note_div[c*DIV_W +: DIV_W] = DIV_W'(nd);
        volume[c*VOL_W +: VOL_W]   = VOL_W'(v);
        mute[c]                    = m;
    endtask

    initial begin
        int prev;
        int mx;
        int mn;
        for (int v = 0; v < 8; v++) amp_tab[v].vol = v;
        amp_tab[0].amp = 0;    amp_tab[1].amp = 383;  amp_tab[2].amp = 767;
        amp_tab[3].amp = 1535; amp_tab[4].amp = 3071; amp_tab[5].amp = 6143;
        amp_tab[6].amp = 12287; amp_tab[7].amp = 24575;

        rst = 1'b1; note_div = '0; volume = '0; mute = '0;
        model_reset();
        repeat (2) step();
        chk("reset mix", $signed(mix_sample), 0);
        chk("reset ch0", dut_samp(0), 0);
        @(negedge clk) rst = 1'b0;

        // volume table on a long phase-0 half-period
        set_ch(0, 200, 7, 0);
        step();
        for (int i = 0; i < 8; i++) begin
            set_ch(0, 200, amp_tab[i].vol, 0);
            step();
            chk($sformatf("amp vol=%0d", amp_tab[i].vol), dut_samp(0), amp_tab[i].amp);
        end
        set_ch(0, 0, 7, 0);
        repeat (210) step();

        // basic tone: 4 cycles +A, 4 cycles -A, tick every 8
        set_ch(0, 4, 7, 0);
        step();
        prev = 0;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk($sformatf("tone4 sample i=%0d", i), dut_samp(0), (((i - 1) / 4) % 2 == 0) ? FULL : -FULL);
            chk($sformatf("tone4 tick i=%0d", i), period_tick[0], (i == 9) ? 1 : 0);
            if (i >= 2) chk($sformatf("tone4 mix i=%0d", i), $signed(mix_sample), prev);
            prev = dut_samp(0);
        end

        // retune mid half-period, then vol 5, then a 3-cycle mute
        repeat (2) step();
        set_ch(0, 6, 7, 0);
        repeat (30) step();
        set_ch(0, 6, 5, 0);
        repeat (8) step();
        set_ch(0, 6, 5, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("muted sample", dut_samp(0), 0);
        end
        set_ch(0, 6, 5, 0);
        repeat (20) step();

        // in-phase saturation
        set_ch(0, 0, 7, 0);
        repeat (20) step();
        set_ch(0, 8, 7, 0); set_ch(1, 8, 7, 0);
        mx = 0; mn = 0;
        repeat (40) begin
            step();
            if ($signed(mix_sample) > mx) mx = $signed(mix_sample);
            if ($signed(mix_sample) < mn) mn = $signed(mix_sample);
        end
        chk("sat max", mx, 32767);
        chk("sat min", mn, -32768);

        // opposite phases cancel
        set_ch(0, 0, 7, 0); set_ch(1, 0, 7, 0);
        repeat (20) step();
        set_ch(0, 4, 7, 0);
        repeat (4) step();
        set_ch(1, 4, 7, 0);
        repeat (3) step();
        repeat (8) begin
            step();
            chk("opposite mix", $signed(mix_sample), 0);
        end

        // div 1 toggles every cycle, then note_div 0 silences
        set_ch(0, 0, 7, 0); set_ch(1, 0, 7, 0);
        repeat (20) step();
        set_ch(0, 1, 7, 0);
        repeat (2) step();
        prev = dut_samp(0);
        repeat (6) begin
            step();
            chk("div1 toggle", dut_samp(0), -prev);
            prev = dut_samp(0);
        end
        set_ch(0, 0, 7, 0);
        repeat (3) step();
        repeat (3) begin
            step();
            chk("div0 silent", dut_samp(0), 0);
        end
        set_ch(0, 3, 7, 0);
        repeat (12) step();

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0)
                set_ch($urandom_range(0, NUM_CH - 1), $urandom_range(0, 7),
                       $urandom_range(0, 7), $urandom_range(0, 15) == 0);
            step();
        end

        // asynchronous reset mid-tone
        set_ch(0, 5, 7, 0); set_ch(1, 3, 7, 0);
        repeat (12) step();
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("async rst ch0", dut_samp(0), 0);
        chk("async rst ch1", dut_samp(1), 0);
        chk("async rst mix", $signed(mix_sample), 0);
        chk("async rst tick", period_tick, 0);
        repeat (2) step();
        #3 rst = 1'b0;
        step();
        step();
        chk("restart +A", dut_samp(0), FULL);
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tone_synth.md
# tone_synth

Parametrised multi-channel square-wave tone generator feeding the audio DAC serialiser. Each channel divides the system clock by a programmable half-period, applies per-channel volume and mute, and produces a signed sample. A saturating mixer sums all channels into one mono sample. Divider changes take effect only at half-period boundaries, so retuning never produces runt pulses.

## Interface
- NUM_CH, 2: number of tone channels (1..8)
- DIV_W, 22: half-period divider width
- SAMPLE_W, 16: signed sample width
- VOL_W, 3: volume code width
- AMP_MAX, 24575: peak amplitude at full volume (must be < 2^(SAMPLE_W-1))
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- note_div  in  NUM_CH*DIV_W  per-channel half-period in clk cycles; 0 = channel off; channel i at bits [i*DIV_W +: DIV_W]
- volume  in  NUM_CH*VOL_W  per-channel volume code; 0 = silent, max code = AMP_MAX
- mute  in  NUM_CH  per-channel mute; counters keep running
- ch_sample  out  NUM_CH*SAMPLE_W  registered signed per-channel sample
- mix_sample  out  SAMPLE_W  registered saturated sum of all ch_sample
- period_tick  out  NUM_CH  one-cycle pulse at completion of each full tone period

## Operation
- Per channel state: div_q (DIV_W), cnt (DIV_W), phase (1 bit), active = (div_q != 0).
- Idle (div_q == 0): cnt = 0, phase = 0; every cycle div_q <= note_div. Loading a nonzero value starts the tone with cnt = 0, phase = 0.
- Active: cnt increments each cycle. When cnt == div_q-1 (boundary): cnt <= 0, phase <= ~phase, div_q <= note_div (resampled). Mid-half-period changes of note_div are ignored until the next boundary.
- note_div -> 0 while active: the current half-period completes, then the channel goes idle with phase = 0.
- div_q == 1: boundary every cycle; phase toggles every cycle.
- Amplitude: A = 0 if vol == 0, else AMP_MAX >> (2^VOL_W-1 - vol). Integer shift, truncating.
- Sample: if active and !mute, phase 0 -> +A, phase 1 -> -A (two's complement); otherwise 0.
- period_tick asserted for one cycle when phase goes 1 -> 0 at a boundary. A full period is 2*div_q cycles.
- Mixer: signed sum of all ch_sample at width SAMPLE_W+clog2(NUM_CH)+1, clamped to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
- volume and mute are sampled every cycle and are not boundary-aligned.

## Timing
- Reset: div_q, cnt, phase = 0; ch_sample, mix_sample, period_tick = 0. Takes effect asynchronously, mid-tone included.
- Counter/phase update at edge N -> ch_sample and period_tick reflect it at edge N+1 -> mix_sample at edge N+2.
- Idle channel loading D at edge k: ch_sample = +A from edge k+1. Phase 1 starts at edge k+D, and ch_sample = -A from edge k+D+1.
- Channels are fully independent; simultaneous boundaries on all channels need no arbitration.

## Structure
- Package tone_pkg: function amp_of(vol) implementing the shift rule, function sat(sum) for mixer clamping, and the AMP_MAX default constant.
- Sub-module tone_channel (divider, phase, sample register, tick), instantiated NUM_CH times with generate. The mixer stays in tone_synth.

## Test plan
- Reset, ch0 note_div=4, vol=7, others 0: ch_sample[0] alternates +24575 for 4 cycles and -24575 for 4 cycles; period_tick[0] pulses every 8 cycles; mix_sample equals ch_sample[0] delayed one cycle.
- Change note_div 4 -> 6 two cycles into a half-period: that half-period still lasts 4 cycles, and the following half-periods last 6.
- vol=5 gives ±6143; vol=0 gives 0. Assert mute for 3 cycles: output 0, and phase continuity holds on release (no period restart).
- NUM_CH=2, both channels in phase at vol 7: mix = +32767 (saturated from 49150) and -32768 (saturated from -49150). Opposite phases: mix = 0.
- note_div=1: sample toggles sign every cycle. Then note_div=0: silence after the current boundary, with phase left at 0.
- Assert rst mid-tone, asynchronously between edges: all outputs 0 immediately. Deassert: the tone restarts from phase 0 with +A.
